// File: rtl/zero_revise_cal_if.sv
// Sample-stream bundle for zero_revise_cal: raw distance in, corrected distance out.
// The DUT side uses the slave modport; the producer/observer side uses master.
interface zero_revise_cal_if #(
   parameter int DW = 16
);
   logic          data_in_valid;
   logic [DW-1:0] data_in;
   logic          data_out_valid;
   logic [DW-1:0] data_out;

   modport master (
      output data_in_valid,
      output data_in,
      input  data_out_valid,
      input  data_out
   );

   modport slave (
      input  data_in_valid,
      input  data_in,
      output data_out_valid,
      output data_out
   );
endinterface

// File: rtl/zero_revise_cal.sv
// Zero-offset correction of distance samples with on-chip offset calibration.
// Optional calibration timeout is built in when ZERO_CAL_TIMEOUT_EN is defined.
module zero_revise_cal #(
   parameter int DW          = 16,
   parameter int AVG_SHIFT   = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DW-1:0]      zero_value,
   input  logic               zero_sel,
   input  logic               cal_start,
   zero_revise_cal_if.slave   dio,
   output logic               cal_busy,
   output logic               cal_done,
   output logic               cal_err,
   output logic [DW-1:0]      learned_zero
);
   localparam int AW = DW + AVG_SHIFT;
   localparam int CW = AVG_SHIFT + 1;
   localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};
   localparam logic [CW-1:0] CNT_LAST = CW'((32'd1 << AVG_SHIFT) - 32'd1);

   typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [AW-1:0] acc_r;
   logic [AW-1:0] acc_sum_s;
   logic [CW-1:0] cnt_r;
   logic [DW-1:0] zero_eff_s;
   logic [DW-1:0] learned_zero_r;
   logic [DW-1:0] data_out_r;
   logic          data_out_valid_r;
   logic          cal_done_r;
   logic          sample_ok_s;
   logic          last_s;
   logic          tmo_hit_s;
   logic          cal_busy_s;
   logic          acc_clr_s;
   logic          acc_add_s;
   logic          done_s;

   assign sample_ok_s = dio.data_in_valid && (dio.data_in != ALL_ONES);
   assign last_s      = sample_ok_s && (cnt_r == CNT_LAST);
   assign acc_sum_s   = acc_r + {{AVG_SHIFT{1'b0}}, dio.data_in};
   assign zero_eff_s  = zero_sel ? learned_zero_r : zero_value;

   // Calibration state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state: a start pulse always (re)enters ACCUM, so completion/timeout lose to it
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (cal_start) state_nxt_s = ACCUM;
            else           state_nxt_s = IDLE;
         end
         ACCUM: begin
            if (cal_start)      state_nxt_s = ACCUM;
            else if (last_s)    state_nxt_s = IDLE;
            else if (tmo_hit_s) state_nxt_s = IDLE;
            else                state_nxt_s = ACCUM;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: accumulator control and completion strobe
   always_comb begin
      cal_busy_s = 1'b0;
      acc_clr_s  = 1'b0;
      acc_add_s  = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         IDLE: begin
            acc_clr_s = cal_start;
         end
         ACCUM: begin
            cal_busy_s = 1'b1;
            if (cal_start) begin
               acc_clr_s = 1'b1;
            end else begin
               acc_add_s = sample_ok_s;
               done_s    = last_s;
            end
         end
         default: begin
            cal_busy_s = 1'b0;
         end
      endcase
   end

   // Accumulator, sample counter and learned offset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r          <= {AW{1'b0}};
         cnt_r          <= {CW{1'b0}};
         learned_zero_r <= {DW{1'b0}};
         cal_done_r     <= 1'b0;
      end else begin
         cal_done_r <= done_s;
         if (acc_clr_s) begin
            acc_r <= {AW{1'b0}};
            cnt_r <= {CW{1'b0}};
         end else if (acc_add_s) begin
            acc_r <= acc_sum_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
         end
         // Truncating average; the accumulator is wide enough never to wrap
         if (done_s) learned_zero_r <= DW'(acc_sum_s >> AVG_SHIFT);
         else        learned_zero_r <= learned_zero_r;
      end
   end

   // Corrected-distance pipeline stage; runs every cycle regardless of valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_valid_r <= 1'b0;
         data_out_r       <= ALL_ONES;
      end else begin
         data_out_valid_r <= dio.data_in_valid;
         if ((dio.data_in != ALL_ONES) && (dio.data_in > zero_eff_s)) begin
            data_out_r <= dio.data_in - zero_eff_s;
         end else begin
            data_out_r <= ALL_ONES;
         end
      end
   end

`ifdef ZERO_CAL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] tmo_cnt_r;
   logic          cal_err_r;
   logic          err_s;

   assign tmo_hit_s = (state_r == ACCUM) && (tmo_cnt_r == TMO_LAST);
   assign err_s     = tmo_hit_s && !cal_start && !last_s;

   // Timeout counter counts every cycle spent in ACCUM since the last start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= {TW{1'b0}};
         cal_err_r <= 1'b0;
      end else begin
         cal_err_r <= err_s;
         if (acc_clr_s)       tmo_cnt_r <= {TW{1'b0}};
         else if (cal_busy_s) tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
         else                 tmo_cnt_r <= tmo_cnt_r;
      end
   end

   assign cal_err = cal_err_r;
`else
   assign tmo_hit_s = 1'b0;
   assign cal_err   = 1'b0;
`endif

   assign cal_busy           = cal_busy_s;
   assign cal_done           = cal_done_r;
   assign learned_zero       = learned_zero_r;
   assign dio.data_out_valid = data_out_valid_r;
   assign dio.data_out       = data_out_r;
endmodule

// File: tb/tb_zero_revise_cal.sv
// Self-checking bench for zero_revise_cal (AVG_SHIFT=2, TIMEOUT_CYC=16).
module tb_zero_revise_cal;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] zero_value = 16'h0;
   logic        zero_sel = 1'b0;
   logic        cal_start = 1'b0;
   logic        cal_busy, cal_done, cal_err;
   logic [15:0] learned_zero;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   logic [15:0] exp_q[$];

   zero_revise_cal_if #(.DW(16)) dio();

   zero_revise_cal #(.DW(16), .AVG_SHIFT(2), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n), .zero_value(zero_value), .zero_sel(zero_sel),
      .cal_start(cal_start), .dio(dio), .cal_busy(cal_busy), .cal_done(cal_done),
      .cal_err(cal_err), .learned_zero(learned_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sel;
      logic [15:0] zv;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic sel, input logic [15:0] zv, input logic st,
                       input logic v, input logic [15:0] d, input logic [15:0] exp);
      @(posedge clk); #1;
      zero_sel = sel;
      zero_value = zv;
      cal_start = st;
      dio.data_in_valid = v;
      dio.data_in = d;
      if (v) exp_q.push_back(exp);
   endtask

   task automatic idle();
      send(zero_sel, zero_value, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   // Scoreboard: every valid output must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n) begin
         if (cal_done) done_cnt++;
         if (cal_err) err_cnt++;
         if (dio.data_out_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got %0h expected none", dio.data_out);
            end else begin
               check("data_out", {16'h0, dio.data_out}, {16'h0, exp_q.pop_front()});
            end
         end
      end
   end

   vec_t vecs[10];
   int   d0;

   initial begin
      vecs[0] = '{1'b0, 16'h0064, 16'h0500, 16'h049C};
      vecs[1] = '{1'b0, 16'h0064, 16'h0064, 16'hFFFF};
      vecs[2] = '{1'b0, 16'h0064, 16'h0010, 16'hFFFF};
      vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF};
      vecs[4] = '{1'b0, 16'h0000, 16'hFFFF, 16'hFFFF};
      vecs[5] = '{1'b1, 16'h0064, 16'd1103, 16'd1000};
      vecs[6] = '{1'b1, 16'h0064, 16'd103,  16'hFFFF};
      vecs[7] = '{1'b1, 16'h0064, 16'd200,  16'd97};
      vecs[8] = '{1'b0, 16'h0010, 16'h0020, 16'h0010};
      vecs[9] = '{1'b1, 16'h0010, 16'd104,  16'd1};

      dio.data_in_valid = 1'b0;
      dio.data_in = 16'h0;
      #12;
      check("rst_valid", {31'h0, dio.data_out_valid}, 32'h0);
      check("rst_data", {16'h0, dio.data_out}, 32'h0000FFFF);
      check("rst_busy", {31'h0, cal_busy}, 32'h0);
      check("rst_done", {31'h0, cal_done}, 32'h0);
      check("rst_err", {31'h0, cal_err}, 32'h0);
      check("rst_learned", {16'h0, learned_zero}, 32'h0);
      #1 rst_n = 1'b1;

      // Static mode, back-to-back samples
      for (int i = 0; i < 5; i++) send(vecs[i].sel, vecs[i].zv, 1'b0, 1'b1, vecs[i].din, vecs[i].exp);
      idle();

      // Calibration: 100,102,(invalid),104,106 -> 103
      send(1'b0, 16'h0064, 1'b1, 1'b0, 16'h0, 16'h0);
      send(1'b0, 16'h0064, 1'b0, 1'b1, 16'd100, 16'hFFFF);
      @(negedge clk) check("busy_s0", {31'h0, cal_busy}, 32'h1);
      send(1'b0, 16'h0064, 1'b0, 1'b1, 16'd102, 16'd2);
      @(negedge clk) check("busy_s1", {31'h0, cal_busy}, 32'h1);
      send(1'b0, 16'h0064, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
      @(negedge clk) check("busy_s2", {31'h0, cal_busy}, 32'h1);
      send(1'b0, 16'h0064, 1'b0, 1'b1, 16'd104, 16'd4);
      @(negedge clk) check("busy_s3", {31'h0, cal_busy}, 32'h1);
      send(1'b0, 16'h0064, 1'b0, 1'b1, 16'd106, 16'd6);
      @(negedge clk) begin
         check("busy_s4", {31'h0, cal_busy}, 32'h1);
         check("no_early_done", {31'h0, cal_done}, 32'h0);
      end
      idle();
      @(negedge clk) begin
         check("cal_done", {31'h0, cal_done}, 32'h1);
         check("busy_after", {31'h0, cal_busy}, 32'h0);
         check("learned_103", {16'h0, learned_zero}, 32'd103);
      end
      idle();
      @(negedge clk) check("done_pulse", {31'h0, cal_done}, 32'h0);

      // Learned mode and zero_sel switching, back-to-back
      for (int i = 5; i < 10; i++) send(vecs[i].sel, vecs[i].zv, 1'b0, 1'b1, vecs[i].din, vecs[i].exp);
      idle();

      // Restart discards earlier samples and the sample coinciding with cal_start
      d0 = done_cnt;
      send(1'b1, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
      send(1'b1, 16'h0, 1'b0, 1'b1, 16'd500, 16'd397);
      send(1'b1, 16'h0, 1'b0, 1'b1, 16'd500, 16'd397);
      send(1'b1, 16'h0, 1'b1, 1'b1, 16'd500, 16'd397);
      for (int i = 0; i < 4; i++) send(1'b1, 16'h0, 1'b0, 1'b1, 16'd200, 16'd97);
      send(1'b1, 16'h0, 1'b0, 1'b1, 16'd300, 16'd100);
      idle();
      idle();
      @(negedge clk) begin
         check("restart_learned", {16'h0, learned_zero}, 32'd200);
         check("restart_one_done", done_cnt - d0, 32'd1);
      end

      // Timeout behaviour: two samples then silence
      d0 = err_cnt;
      send(1'b0, 16'h0064, 1'b1, 1'b0, 16'h0, 16'h0);
      send(1'b0, 16'h0064, 1'b0, 1'b1, 16'd150, 16'h0032);
      send(1'b0, 16'h0064, 1'b0, 1'b1, 16'd150, 16'h0032);
      for (int i = 0; i < 30; i++) idle();
      @(negedge clk) begin
`ifdef ZERO_CAL_TIMEOUT_EN
         check("tmo_err_once", err_cnt - d0, 32'd1);
         check("tmo_busy_low", {31'h0, cal_busy}, 32'h0);
`else
         check("no_tmo_err", err_cnt - d0, 32'd0);
         check("no_tmo_busy", {31'h0, cal_busy}, 32'h1);
`endif
         check("tmo_learned", {16'h0, learned_zero}, 32'd200);
      end

      // Asynchronous reset mid-calibration
      d0 = done_cnt;
      send(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
      send(1'b0, 16'h0, 1'b0, 1'b1, 16'd50, 16'd50);
      send(1'b0, 16'h0, 1'b0, 1'b1, 16'd50, 16'd50);
      idle();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'h0, dio.data_out_valid}, 32'h0);
      check("arst_data", {16'h0, dio.data_out}, 32'h0000FFFF);
      check("arst_busy", {31'h0, cal_busy}, 32'h0);
      check("arst_learned", {16'h0, learned_zero}, 32'h0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) send(1'b0, 16'h0, 1'b0, 1'b1, 16'd10, 16'd10);
      idle();
      idle();
      @(negedge clk) begin
         check("post_rst_no_done", done_cnt - d0, 32'd0);
         check("post_rst_busy", {31'h0, cal_busy}, 32'h0);
         check("post_rst_learned", {16'h0, learned_zero}, 32'h0);
      end
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/zero_revise_cal.md
Name: zero_revise_cal

Overview:
Parametrised zero-offset correction for the distance pipeline; sits directly after the raw time-of-flight distance calculation and before filtering and packetising.
- Subtracts a zero offset from each valid distance sample.
- The offset is either the static register value or a value learned on-chip by averaging 2^AVG_SHIFT samples taken against the calibration target.
- Samples at or below zero map to the all-ones invalid code.

Parameters:
DW, 16, data and offset width in bits
AVG_SHIFT, 4, log2 of calibration sample count (16 samples default; legal 1..8)
TIMEOUT_CYC, 1000000, calibration timeout in clk cycles (used only with ZERO_CAL_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
zero_value  input  DW  static zero offset from the register block
zero_sel  input  1  0 = use zero_value, 1 = use learned_zero
cal_start  input  1  one-cycle pulse, starts or restarts calibration
data_in_valid  input  1  input sample strobe
data_in  input  DW  raw distance; all-ones = invalid
data_out_valid  output  1  output sample strobe
data_out  output  DW  corrected distance; all-ones = invalid
cal_busy  output  1  high while calibration is accumulating
cal_done  output  1  one-cycle pulse, learned_zero updated
cal_err  output  1  one-cycle pulse, calibration timed out
learned_zero  output  DW  current learned offset

Behaviour:
Reset (rst_n low, asynchronous): data_out_valid=0, data_out=all-ones, cal_busy=0, cal_done=0, cal_err=0, learned_zero=0, state IDLE, accumulator and counters 0.
Data path (fixed 1-cycle latency, registered, no backpressure):
- data_out_valid <= data_in_valid every cycle.
- zero_eff = zero_sel ? learned_zero : zero_value, sampled combinationally in the same cycle as data_in.
- data_out <= (data_in != all-ones && data_in > zero_eff) ? data_in - zero_eff : all-ones.
- data_in == zero_eff gives all-ones.
- data_out updates every cycle regardless of valid.
Calibration FSM, states IDLE and ACCUM:
- IDLE: cal_start=1 -> ACCUM; clear acc (width DW+AVG_SHIFT, cannot overflow), sample count and timeout counter.
- ACCUM: cal_busy=1. Each cycle with data_in_valid=1 and data_in != all-ones: acc += data_in, count += 1. Invalid-code samples are skipped and not counted.
- Completion: the sample that brings count to 2^AVG_SHIFT causes learned_zero <= (acc + data_in) >> AVG_SHIFT (truncating) on the next edge, cal_done=1 for one cycle, -> IDLE.
- cal_start in ACCUM restarts: acc, count and timeout cleared; stay in ACCUM; the sample in the same cycle is discarded.
- learned_zero holds its old value during ACCUM. The data path keeps using the old value until the cal_done cycle. Samples arriving on or after the cal_done cycle use the new value.
- zero_sel may change at any time; it takes effect on the next sample.
- rst_n asserted mid-calibration aborts it; learned_zero returns to 0; no cal_done or cal_err is issued.

Optional Feature:
Macro ZERO_CAL_TIMEOUT_EN.
- Defined: a cycle counter runs in ACCUM. When TIMEOUT_CYC cycles elapse without completion: -> IDLE, cal_err=1 for one cycle, learned_zero unchanged, no cal_done.
- Completion and timeout in the same cycle: completion wins.
- Not defined: no timeout counter; cal_err is tied to 0; ACCUM waits indefinitely.

Test Plan:
- Static mode: zero_sel=0, zero_value=0x0064, data_in 0x0500 valid -> next cycle data_out=0x049C, data_out_valid=1. Data_in 0x0064 -> 0xFFFF. Data_in 0x0010 -> 0xFFFF.
- Calibration: AVG_SHIFT=2; cal_start, then valid 100, 102, 0xFFFF, 104, 106 -> cal_busy high throughout; the 0xFFFF sample is skipped; cal_done one cycle after sample 106; learned_zero=103.
- Learned mode: after the previous scenario, zero_sel=1, data_in 1103 -> data_out 1000. Data_in 103 -> 0xFFFF. Back-to-back valid samples give one output per cycle.
- Restart: cal_start after two samples of 500, then four samples of 200 -> learned_zero=200, exactly one cal_done.
- Reset mid-calibration: assert rst_n low after two samples -> all outputs at reset values immediately (asynchronous). After release, four samples give no cal_done until a new cal_start.
- Timeout (macro defined, TIMEOUT_CYC=16): cal_start, two valid samples, then idle -> cal_err pulses at cycle 16 of ACCUM, learned_zero unchanged, cal_busy low. Macro undefined: cal_busy remains high.
